test_monitor: RTL

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/test_monitor.sv
// test_monitor: watches the CPU t6 debug tap and reports test pass/fail/timeout.
//   clk         : rising-edge clock
//   rstn        : asynchronous active-low reset
//   en          : run/pause control (IDLE -> RUN, freezes RUN when low)
//   clr         : synchronous restart to IDLE, clears all progress
//   dbg_t6      : sampled t6 register value
//   done        : any terminal state reached
//   pass/fail/timeout : one-hot terminal flags
//   fail_code   : dbg_t6[27:0] captured on the failing sample
//   cycle_count : RUN cycles counted with en=1
//   t6_changes  : saturating count of dbg_t6 value changes
module test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter logic [31:0] PASS_VALUE     = 32'h0000_0001,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] dbg_t6,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [27:0] fail_code,
    output logic [31:0] cycle_count,
    output logic [15:0] t6_changes
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned CHG_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   stable_cnt;
    logic [31:0]        prev_t6;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   stable_inc;
    logic               run_active;
    logic               fail_tag;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; priority clr > FAIL > PASS > TIMEOUT
    always_comb begin
        state_d    = state_q;
        run_active = 1'b0;
        count_inc  = cycle_count + CNT_W'(1);
        stable_inc = (dbg_t6 == PASS_VALUE) ? stable_cnt + CNT_W'(1) : '0;
        fail_tag   = (dbg_t6[31:28] == 4'hF);
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) state_d = S_RUN;
                end
                S_RUN: begin
                    if (en) begin
                        run_active = 1'b1;
                        if (fail_tag) begin
                            state_d = S_FAIL;
                        end else if (stable_inc == CNT_W'(STABLE_CYCLES)) begin
                            state_d = S_PASS;
                        end else if (count_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                            state_d = S_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Counters, captured code and flags; flags follow the state being entered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
            t6_changes  <= '0;
            stable_cnt  <= '0;
            prev_t6     <= '0;
        end else if (clr) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
            t6_changes  <= '0;
            stable_cnt  <= '0;
            prev_t6     <= '0;
        end else begin
            done    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
            pass    <= (state_d == S_PASS);
            fail    <= (state_d == S_FAIL);
            timeout <= (state_d == S_TIMEOUT);
            if (run_active) begin
                cycle_count <= count_inc;
                stable_cnt  <= stable_inc;
                prev_t6     <= dbg_t6;
                if ((dbg_t6 != prev_t6) && (t6_changes != {CHG_W{1'b1}})) begin
                    t6_changes <= t6_changes + CHG_W'(1);
                end
                if (fail_tag) begin
                    fail_code <= dbg_t6[27:0];
                end
            end
        end
    end

endmodule
